// File: rtl/wb_block_reader.sv
// Wishbone pipelined read master: fetches a block of consecutive words
// one transaction at a time and streams them out on a valid/ready port.
module wb_block_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [CNT_WIDTH-1:0]  count_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [1:0]            status_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [3:0]            wb_sel_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_rty_i,
  input  logic                  wb_stall_i
);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, OUT, DONE
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] WORD = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ALIGN = ~ADDR_WIDTH'(3);

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [CNT_WIDTH-1:0]  remaining;
  logic [15:0]           tmo_cnt;
  logic [1:0]            status;
  logic [DATA_WIDTH-1:0] data;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    wb_cyc_o    = 1'b0;
    wb_stb_o    = 1'b0;
    out_valid_o = 1'b0;
    done_o      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_i)
          state_nxt = (count_i == '0) ? DONE : REQ;
      end
      REQ: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        if (abort_i)          state_nxt = DONE;
        else if (!wb_stall_i) state_nxt = WAIT;
      end
      WAIT: begin
        wb_cyc_o = 1'b1;
        if (abort_i)                state_nxt = DONE;
        else if (wb_err_i)          state_nxt = DONE;
        else if (wb_ack_i)          state_nxt = OUT;
        else if (wb_rty_i)          state_nxt = REQ;
        else if (tmo_cnt == TMO_LAST) state_nxt = DONE;
      end
      OUT: begin
        out_valid_o = 1'b1;
        if (abort_i)
          state_nxt = DONE;
        else if (out_ready_i)
          state_nxt = (remaining == '0) ? DONE : REQ;
      end
      DONE: begin
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: address, word counter, timeout counter, status and read data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr      <= '0;
      remaining <= '0;
      tmo_cnt   <= '0;
      status    <= 2'b00;
      data      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i) begin
            addr      <= base_i & ALIGN;
            remaining <= count_i;
            tmo_cnt   <= '0;
            status    <= 2'b00;
          end
        end
        REQ: begin
          tmo_cnt <= '0;
          if (abort_i) status <= 2'b11;
        end
        WAIT: begin
          if (abort_i) begin
            status <= 2'b11;
          end else if (wb_err_i) begin
            status <= 2'b01;
          end else if (wb_ack_i) begin
            data      <= wb_dat_i;
            addr      <= addr + WORD;
            remaining <= remaining - CNT_WIDTH'(1);
          end else if (wb_rty_i) begin
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
            if (tmo_cnt == TMO_LAST) status <= 2'b10;
          end
        end
        OUT: begin
          if (abort_i) status <= 2'b11;
        end
        default: ;
      endcase
    end
  end

  assign busy_o     = (state == REQ) || (state == WAIT) || (state == OUT);
  assign status_o   = status;
  assign out_data_o = data;
  assign wb_adr_o   = addr;
  assign wb_we_o    = 1'b0;
  assign wb_sel_o   = 4'b1111;

endmodule
